// File: rtl/pc_branch_unit.sv
`default_nettype none
// =============================================================================
// pc_branch_unit : PC register and next-PC selection with a one-deep redirect
// buffer and fetch/redirect counters.                            Rev 1.0
// =============================================================================
module pc_branch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             imem_ready,
  input  logic             stall,
  input  logic             exec_valid,
  input  logic             branch,
  input  logic             zout,
  input  logic             jump,
  input  logic             jr,
  input  logic [15:0]      imm16,
  input  logic [25:0]      jindex,
  input  logic [31:0]      rs_val,
  output logic [31:0]      pc_out,
  output logic [31:0]      pc_plus4,
  output logic             pc_valid,
  output logic             redirect_pend,
  output logic             jr_misalign,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] taken_count
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t      state;
  logic [31:0] pend_tgt;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic [31:0] jr_tgt;
  logic [31:0] redir_tgt;
  logic        redir;
  logic        adv;
  logic        jr_bad;

  assign pc_plus4 = pc_out + 32'd4;
  assign br_tgt   = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
  assign j_tgt    = {pc_plus4[31:28], jindex, 2'b00};
  assign jr_tgt   = {rs_val[31:2], 2'b00};
  assign adv      = pc_valid & imem_ready & ~stall;
  assign jr_bad   = exec_valid & jr & (rs_val[1:0] != 2'b00);

  // jr outranks jump, which outranks a taken conditional branch
  always_comb begin
    redir     = 1'b0;
    redir_tgt = pc_plus4;
    if (exec_valid) begin
      if (jr) begin
        redir     = 1'b1;
        redir_tgt = jr_tgt;
      end else if (jump) begin
        redir     = 1'b1;
        redir_tgt = j_tgt;
      end else if (branch && zout) begin
        redir     = 1'b1;
        redir_tgt = br_tgt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_BOOT;
      pc_out        <= RESET_PC;
      pend_tgt      <= RESET_PC;
      pc_valid      <= 1'b0;
      redirect_pend <= 1'b0;
      jr_misalign   <= 1'b0;
      instr_count   <= '0;
      taken_count   <= '0;
    end else begin
      case (state)
        ST_BOOT: begin
          state    <= ST_RUN;
          pc_valid <= 1'b1;
        end
        ST_RUN: begin
          if (jr_bad) begin
            jr_misalign <= 1'b1;
          end
          if (adv) begin
            pc_out      <= redir ? redir_tgt : pc_plus4;
            instr_count <= instr_count + CNT_ONE;
            if (redir) begin
              taken_count <= taken_count + CNT_ONE;
            end
          end else if (redir) begin
            // Fetch not accepted: park the target until the fetch can advance
            pend_tgt      <= redir_tgt;
            redirect_pend <= 1'b1;
            state         <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (adv) begin
            pc_out        <= pend_tgt;
            instr_count   <= instr_count + CNT_ONE;
            taken_count   <= taken_count + CNT_ONE;
            redirect_pend <= 1'b0;
            state         <= ST_RUN;
          end
        end
        default: begin
          state         <= ST_BOOT;
          pc_valid      <= 1'b0;
          redirect_pend <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_branch_unit.sv
`default_nettype none
// =============================================================================
// tb_pc_branch_unit : directed scoreboard bench for pc_branch_unit.  Rev 1.0
// =============================================================================
module tb_pc_branch_unit;

  logic        clk = 1'b0;
  logic        reset, reset_b;
  logic        imem_ready, stall, exec_valid, branch, zout, jump, jr;
  logic [15:0] imm16;
  logic [25:0] jindex;
  logic [31:0] rs_val;

  logic [31:0] pc_out, pc_plus4, instr_count, taken_count;
  logic        pc_valid, redirect_pend, jr_misalign;

  logic [31:0] pc_out_b, pc_plus4_b;
  logic        pc_valid_b, redirect_pend_b, jr_misalign_b;
  logic [2:0]  instr_count_b, taken_count_b;

  always #5 clk = ~clk;

  pc_branch_unit dut (
    .clk(clk), .reset(reset), .imem_ready(imem_ready), .stall(stall),
    .exec_valid(exec_valid), .branch(branch), .zout(zout), .jump(jump), .jr(jr),
    .imm16(imm16), .jindex(jindex), .rs_val(rs_val),
    .pc_out(pc_out), .pc_plus4(pc_plus4), .pc_valid(pc_valid),
    .redirect_pend(redirect_pend), .jr_misalign(jr_misalign),
    .instr_count(instr_count), .taken_count(taken_count)
  );

  // Second instance: PC near the top of memory and a 3-bit counter for wrap checks
  pc_branch_unit #(.RESET_PC(32'hFFFF_FFF0), .CNT_W(3)) dut_b (
    .clk(clk), .reset(reset_b), .imem_ready(imem_ready), .stall(stall),
    .exec_valid(exec_valid), .branch(branch), .zout(zout), .jump(jump), .jr(jr),
    .imm16(imm16), .jindex(jindex), .rs_val(rs_val),
    .pc_out(pc_out_b), .pc_plus4(pc_plus4_b), .pc_valid(pc_valid_b),
    .redirect_pend(redirect_pend_b), .jr_misalign(jr_misalign_b),
    .instr_count(instr_count_b), .taken_count(taken_count_b)
  );

  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic        pend;
    logic        mis;
    logic [31:0] ic;
    logic [31:0] tc;
    logic        on_b;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   step_no = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s step=%0d observed=%h expected=%h", tag, step_no, obs, expv);
    end
  endtask

  task automatic clr_exec();
    exec_valid = 1'b0; branch = 1'b0; zout = 1'b0; jump = 1'b0; jr = 1'b0;
    imm16 = 16'h0; jindex = 26'h0; rs_val = 32'h0;
  endtask

  // Push the expectation for the coming edge, clock, then pop and compare
  task automatic cyc(input logic [31:0] pc, input logic valid, input logic pend,
                     input logic mis, input logic [31:0] ic, input logic [31:0] tc,
                     input logic on_b);
    exp_t e;
    exp_t g;
    e.pc = pc; e.valid = valid; e.pend = pend; e.mis = mis;
    e.ic = ic; e.tc = tc; e.on_b = on_b;
    q.push_back(e);
    @(posedge clk);
    #1;
    step_no++;
    g = q.pop_front();
    if (!g.on_b) begin
      chk("pc_out", pc_out, g.pc);
      chk("pc_plus4", pc_plus4, g.pc + 32'd4);
      chk("pc_valid", {31'b0, pc_valid}, {31'b0, g.valid});
      chk("redirect_pend", {31'b0, redirect_pend}, {31'b0, g.pend});
      chk("jr_misalign", {31'b0, jr_misalign}, {31'b0, g.mis});
      chk("instr_count", instr_count, g.ic);
      chk("taken_count", taken_count, g.tc);
    end else begin
      chk("b_pc_out", pc_out_b, g.pc);
      chk("b_pc_plus4", pc_plus4_b, g.pc + 32'd4);
      chk("b_pc_valid", {31'b0, pc_valid_b}, {31'b0, g.valid});
      chk("b_instr_count", {29'b0, instr_count_b}, g.ic);
      chk("b_taken_count", {29'b0, taken_count_b}, g.tc);
    end
  endtask

  initial begin
    reset = 1'b1; reset_b = 1'b1; imem_ready = 1'b1; stall = 1'b0;
    clr_exec();

    // Reset held two cycles
    cyc(32'h0, 0, 0, 0, 0, 0, 0);
    cyc(32'h0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    cyc(32'h0, 1, 0, 0, 0, 0, 0);            // BOOT -> RUN, no fetch yet
    cyc(32'h4, 1, 0, 0, 1, 0, 0);
    cyc(32'h8, 1, 0, 0, 2, 0, 0);
    cyc(32'hC, 1, 0, 0, 3, 0, 0);
    cyc(32'h10, 1, 0, 0, 4, 0, 0);

    // Jump to 0x100
    exec_valid = 1; jump = 1; jindex = 26'h40;
    cyc(32'h100, 1, 0, 0, 5, 1, 0);
    clr_exec();
    // Taken backward branch: 0x104 - 16
    exec_valid = 1; branch = 1; zout = 1; imm16 = 16'hFFFC;
    cyc(32'hF4, 1, 0, 0, 6, 2, 0);
    zout = 0;
    cyc(32'hF8, 1, 0, 0, 7, 2, 0);
    zout = 1; imm16 = 16'h0001;
    cyc(32'h100, 1, 0, 0, 8, 3, 0);
    zout = 0; imm16 = 16'hFFFC;
    cyc(32'h104, 1, 0, 0, 9, 3, 0);
    clr_exec();

    // jr beats jump; misaligned rs_val sets the sticky flag
    exec_valid = 1; jr = 1; rs_val = 32'h4000_0010;
    cyc(32'h4000_0010, 1, 0, 0, 10, 4, 0);
    jump = 1; jindex = 26'h40; rs_val = 32'h0000_2003;
    cyc(32'h0000_2000, 1, 0, 1, 11, 5, 0);
    jump = 0; rs_val = 32'h4000_0010;
    cyc(32'h4000_0010, 1, 0, 1, 12, 6, 0);
    jr = 0; jump = 1; jindex = 26'h40;
    cyc(32'h4000_0100, 1, 0, 1, 13, 7, 0);
    exec_valid = 0;                          // decoded jump without exec_valid
    cyc(32'h4000_0104, 1, 0, 1, 14, 7, 0);
    clr_exec();

    // Redirect while stalled is buffered; later exec inputs are ignored
    exec_valid = 1; jr = 1; rs_val = 32'h20;
    cyc(32'h20, 1, 0, 1, 15, 8, 0);
    clr_exec();
    stall = 1; exec_valid = 1; jump = 1; jindex = 26'h10;
    cyc(32'h20, 1, 1, 1, 15, 8, 0);
    clr_exec();
    exec_valid = 1; jr = 1; rs_val = 32'h0000_1234;
    cyc(32'h20, 1, 1, 1, 15, 8, 0);
    clr_exec();
    stall = 0;
    cyc(32'h40, 1, 0, 1, 16, 9, 0);
    stall = 1;
    cyc(32'h40, 1, 0, 1, 16, 9, 0);
    stall = 0;

    // PEND entered via imem_ready low, then reset mid-PEND
    imem_ready = 0; exec_valid = 1; jump = 1; jindex = 26'h30;
    cyc(32'h40, 1, 1, 1, 16, 9, 0);
    clr_exec();
    cyc(32'h40, 1, 1, 1, 16, 9, 0);
    reset = 1;
    cyc(32'h0, 0, 0, 0, 0, 0, 0);
    reset = 0; imem_ready = 1;
    cyc(32'h0, 1, 0, 0, 0, 0, 0);
    cyc(32'h4, 1, 0, 0, 1, 0, 0);

    // PC and counter wrap on the second instance
    reset = 1;
    cyc(32'hFFFF_FFF0, 0, 0, 0, 0, 0, 1);
    reset_b = 0; reset = 0;
    cyc(32'hFFFF_FFF0, 1, 0, 0, 0, 0, 1);
    cyc(32'hFFFF_FFF4, 1, 0, 0, 1, 0, 1);
    cyc(32'hFFFF_FFF8, 1, 0, 0, 2, 0, 1);
    cyc(32'hFFFF_FFFC, 1, 0, 0, 3, 0, 1);
    cyc(32'h0000_0000, 1, 0, 0, 4, 0, 1);
    cyc(32'h0000_0004, 1, 0, 0, 5, 0, 1);
    cyc(32'h0000_0008, 1, 0, 0, 6, 0, 1);
    cyc(32'h0000_000C, 1, 0, 0, 7, 0, 1);
    cyc(32'h0000_0010, 1, 0, 0, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_branch_unit.md
Name: pc_branch_unit

Overview:
- Program-counter and next-PC stage of the single-cycle MIPS datapath, directly downstream of the 32-bit ALU.
- Consumes the ALU zero flag (zout) for branch resolution, plus decoded jump, jr and immediate fields, and produces the fetch address for instruction memory.
- Holds the PC register, handles a fetch ready/stall handshake, buffers a redirect that cannot be applied immediately, and keeps two performance counters.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high reset
- imem_ready  input  1  instruction memory accepts pc_out this cycle
- stall  input  1  hazard/stall hold from control
- exec_valid  input  1  exec inputs below are valid for the instruction at pc_out
- branch  input  1  instruction is a conditional branch (BEQ/BNE/BGEZ/BGTZ/BLEZ/BLTZ)
- zout  input  1  ALU zero flag; for branch ALU codes, 1 = condition true (taken)
- jump  input  1  J/JAL
- jr  input  1  JR/JALR
- imm16  input  16  branch offset, words
- jindex  input  26  jump index field
- rs_val  input  32  register value for jr
- pc_out  output  32  current fetch address
- pc_plus4  output  32  pc_out + 4 (link value)
- pc_valid  output  1  pc_out is a valid fetch request
- redirect_pend  output  1  a redirect is buffered
- jr_misalign  output  1  sticky: jr target had rs_val[1:0] != 0
- instr_count  output  CNT_W  count of accepted fetches
- taken_count  output  CNT_W  count of applied redirects

Behaviour:
- Reset (synchronous, any state, including mid-redirect):
  - pc_out = RESET_PC; pc_valid = 0; redirect_pend = 0; jr_misalign = 0; both counters = 0; state = BOOT.
- States:
  - BOOT: pc_valid = 0; always goes to RUN on the next cycle.
  - RUN: pc_valid = 1.
  - PEND: pc_valid = 1; redirect_pend = 1.
- adv = pc_valid & imem_ready & ~stall.
- Target computation (combinational from current pc_out):
  - pc_plus4 = pc_out + 4, modulo 2^32; wraps from 32'hFFFF_FFFC to 0.
  - br_tgt = pc_plus4 + ({{14{imm16[15]}}, imm16, 2'b00}), modulo 2^32.
  - j_tgt = {pc_plus4[31:28], jindex, 2'b00}.
  - jr_tgt = {rs_val[31:2], 2'b00}.
- Redirect selection, sampled only when exec_valid = 1, in priority order:
  - jr -> jr_tgt;
  - else jump -> j_tgt;
  - else branch & zout -> br_tgt;
  - else no redirect.
  - branch with zout = 0 is not taken. exec_valid = 0 means no redirect.
- RUN:
  - adv with redirect: pc_out <= redirect target; taken_count += 1.
  - adv without redirect: pc_out <= pc_plus4.
  - Every adv: instr_count += 1.
  - Redirect present and no adv: latch target into pend_tgt; go to PEND. pc_out unchanged.
  - No adv, no redirect: hold all state.
- PEND:
  - exec inputs are ignored; the buffered target wins.
  - On adv: pc_out <= pend_tgt; instr_count += 1; taken_count += 1; return to RUN.
  - Otherwise hold.
- jr_misalign sets on the cycle a jr redirect is selected (RUN, exec_valid, jr) with rs_val[1:0] != 0. It stays set until reset. The target still uses jr_tgt.
- Counters wrap modulo 2^CNT_W and never saturate.
- All outputs are registered except pc_plus4, which is derived from the registered pc_out.

Test Plan:
- Reset then run: reset high 2 cycles, then low, imem_ready = 1, no exec_valid -> pc_valid = 0 for the first cycle after reset, then pc_out = 0, 4, 8, 12; instr_count = 4 after 4 advancing cycles.
- Branch taken and not taken: pc_out = 0x100, exec_valid, branch, imm16 = 16'hFFFC, zout = 1 -> next pc_out = 0xF4, taken_count = 1. Same with zout = 0 -> next pc_out = 0x104, taken_count unchanged.
- Jump vs jr priority: pc_out = 0x4000_0010, jump, jindex = 26'h0000040, and jr with rs_val = 0x0000_2003 all asserted -> next pc_out = 0x0000_2000, jr_misalign = 1 and stays 1 until reset. Jump alone -> next pc_out = 0x4000_0100.
- Redirect during stall: pc_out = 0x20, stall = 1, exec_valid, jump, jindex = 26'h10 -> redirect_pend = 1 and pc_out held. Change exec inputs while stalled -> ignored. Release stall -> pc_out = 0x40, redirect_pend = 0, taken_count += 1.
- imem_ready low plus reset mid-PEND: enter PEND via imem_ready = 0, assert reset -> pc_out = RESET_PC, pc_valid = 0, redirect_pend = 0, counters = 0.
- Wrap-around: force pc_out = 0xFFFF_FFFC, advance -> pc_out = 0. Preload instr_count to all-ones, advance -> 0.
